// File: rtl/priority_encoder_rr_if.sv
// Request/grant bundle for priority_encoder_rr: request side, grant side and priority mode.
// grant_oh exists only when PENC_ONEHOT_EN is defined.
interface priority_encoder_rr_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic [N-1:0] In;
    logic         in_valid;
    logic         in_ready;
    logic         mode;
    logic [W-1:0] y_out;
    logic         valid;
    logic         out_ready;
`ifdef PENC_ONEHOT_EN
    logic [N-1:0] grant_oh;
`endif

    modport slave (
        input  In, in_valid, mode, out_ready,
`ifdef PENC_ONEHOT_EN
        output grant_oh,
`endif
        output in_ready, y_out, valid
    );

    modport master (
        output In, in_valid, mode, out_ready,
`ifdef PENC_ONEHOT_EN
        input  grant_oh,
`endif
        input  in_ready, y_out, valid
    );
endinterface

// File: rtl/priority_encoder_rr.sv
// N-request priority encoder, fixed (MSB-highest) or round-robin, registered grant with valid/ready.
// Optional registered one-hot grant output when PENC_ONEHOT_EN is defined.
module priority_encoder_rr #(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    priority_encoder_rr_if.slave  bus
);
    localparam int W = $clog2(N);

    logic [W-1:0] y_q;
    logic         valid_q;
    logic [W-1:0] ptr;
    logic [W-1:0] fixed_idx;
    logic [W-1:0] rr_low;
    logic [W-1:0] rr_hi;
    logic         rr_hi_found;
    logic [W-1:0] grant;
    logic [W-1:0] ptr_next;
    logic         in_ready;
    logic         capture;
    logic         fire;

    assign in_ready = !valid_q || bus.out_ready;
    assign capture  = bus.in_valid && in_ready && (bus.In != '0);
    assign fire     = valid_q && bus.out_ready;

    // Descending scan: last hit wins, so rr_low/rr_hi end up as the lowest matching index.
    always_comb begin
        fixed_idx   = '0;
        rr_low      = '0;
        rr_hi       = '0;
        rr_hi_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (bus.In[i]) fixed_idx = W'(i);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.In[i]) begin
                rr_low = W'(i);
                if (i >= int'(ptr)) begin
                    rr_hi       = W'(i);
                    rr_hi_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant = fixed_idx;
        if (bus.mode) grant = rr_hi_found ? rr_hi : rr_low;
    end

    assign ptr_next = (grant == W'(N - 1)) ? '0 : grant + W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            valid_q <= 1'b0;
            ptr     <= '0;
        end else if (capture) begin
            y_q     <= grant;
            valid_q <= 1'b1;
            if (bus.mode) ptr <= ptr_next;
        end else if (fire) begin
            valid_q <= 1'b0;
        end
    end

`ifdef PENC_ONEHOT_EN
    logic [N-1:0] oh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oh_q <= '0;
        end else if (capture) begin
            oh_q <= N'(1) << grant;
        end else if (fire) begin
            oh_q <= '0;
        end
    end

    assign bus.grant_oh = oh_q;
`endif

    assign bus.in_ready = in_ready;
    assign bus.y_out    = y_q;
    assign bus.valid    = valid_q;
endmodule
